// File: rtl/cpu_run_sequencer.sv
// MMIO run/step sequencer: resets, free-runs, N-steps and halts the CPU and counts cycles/commits.
// Optional breakpoint register is enabled by defining CPU_SEQ_BREAKPOINT_EN.
module cpu_run_sequencer #(
  parameter int RST_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] interface_addr,
  input  logic [31:0] interface_wdata,
  input  logic        interface_we,
  output logic [31:0] interface_rdata,
  output logic        cpu_rst,
  output logic        cpu_global_en,
  input  logic        cpu_commit_en,
  input  logic [31:0] cpu_commit_pc,
  input  logic        cpu_commit_halt
);
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int            CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] rst_cnt_q;
  logic [31:0]   nstep_q, remain_q;
  logic [31:0]   cyc_q, cyc_d, inst_q, inst_d, lpc_q, lpc_d;
  logic          halted_q, bp_hit_q;
`ifdef CPU_SEQ_BREAKPOINT_EN
  logic [31:0]   bp_q;
`endif

  logic [2:0] off;
  logic       cmd_we, c_reset, c_halt, c_step, c_run;
  logic       counted, halt_commit, bp_match;
  logic       unused_addr;

  assign off         = interface_addr[4:2];
  assign unused_addr = ^{interface_addr[31:5], interface_addr[1:0]};

  // One-hot the command with RESET > HALT > STEP > RUN priority.
  assign cmd_we  = interface_we && (off == 3'd0);
  assign c_reset = cmd_we & interface_wdata[3];
  assign c_halt  = cmd_we & interface_wdata[2] & ~interface_wdata[3];
  assign c_step  = cmd_we & interface_wdata[1] & ~|interface_wdata[3:2];
  assign c_run   = cmd_we & interface_wdata[0] & ~|interface_wdata[3:1];

  assign cpu_rst       = (state_q == S_RST);
  assign cpu_global_en = (state_q == S_RUN) || (state_q == S_STEP);

  assign counted     = cpu_global_en & cpu_commit_en;
  assign halt_commit = counted & cpu_commit_halt;
`ifdef CPU_SEQ_BREAKPOINT_EN
  assign bp_match = counted & bp_q[0] & (cpu_commit_pc[31:2] == bp_q[31:2]);
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    cyc_d  = cpu_global_en ? cyc_q + 32'd1 : cyc_q;
    inst_d = counted ? inst_q + 32'd1 : inst_q;
    lpc_d  = counted ? cpu_commit_pc : lpc_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_RST;
      rst_cnt_q <= RST_LOAD;
      nstep_q   <= 32'd1;
      remain_q  <= '0;
      cyc_q     <= '0;
      inst_q    <= '0;
      lpc_q     <= '0;
      halted_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
      bp_q      <= '0;
`endif
    end else begin
      if (interface_we && off == 3'd2) nstep_q <= interface_wdata;
`ifdef CPU_SEQ_BREAKPOINT_EN
      if (interface_we && off == 3'd6) bp_q <= interface_wdata;
`endif
      if (c_reset) begin
        state_q   <= S_RST;
        rst_cnt_q <= RST_LOAD;
        cyc_q     <= '0;
        inst_q    <= '0;
        lpc_q     <= '0;
        halted_q  <= 1'b0;
        bp_hit_q  <= 1'b0;
      end else begin
        cyc_q  <= cyc_d;
        inst_q <= inst_d;
        lpc_q  <= lpc_d;
        case (state_q)
          S_RST: begin
            if (rst_cnt_q == '0) state_q <= S_IDLE;
            else                 rst_cnt_q <= rst_cnt_q - 1'b1;
          end
          S_IDLE: begin
            if (c_step) begin
              state_q  <= S_STEP;
              remain_q <= (nstep_q == '0) ? 32'd1 : nstep_q;
              bp_hit_q <= 1'b0;
            end else if (c_run) begin
              state_q  <= S_RUN;
              bp_hit_q <= 1'b0;
            end
          end
          S_RUN: begin
            if (halt_commit) begin
              state_q  <= S_DONE;
              halted_q <= 1'b1;
            end else if (c_halt) begin
              state_q <= S_IDLE;
            end else if (bp_match) begin
              state_q  <= S_IDLE;
              bp_hit_q <= 1'b1;
            end
          end
          S_STEP: begin
            if (halt_commit) begin
              state_q  <= S_DONE;
              halted_q <= 1'b1;
            end else if (c_halt) begin
              state_q <= S_IDLE;
            end else if (bp_match) begin
              state_q  <= S_IDLE;
              bp_hit_q <= 1'b1;
            end else if (counted) begin
              if (remain_q == 32'd1) state_q <= S_IDLE;
              else                   remain_q <= remain_q - 32'd1;
            end
          end
          S_DONE:  state_q <= S_DONE;
          default: state_q <= S_RST;
        endcase
      end
    end
  end

  always_comb begin
    interface_rdata = '0;
    case (off)
      3'd1: interface_rdata = {27'd0, bp_hit_q, halted_q, state_q};
      3'd2: interface_rdata = nstep_q;
      3'd3: interface_rdata = cyc_q;
      3'd4: interface_rdata = inst_q;
      3'd5: interface_rdata = lpc_q;
`ifdef CPU_SEQ_BREAKPOINT_EN
      3'd6: interface_rdata = bp_q;
`endif
      default: interface_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: directed scenarios with literal expectations plus a random run,
// all checked every cycle against a mode/counter model of the sequencer.
module tb_cpu_run_sequencer;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] interface_addr = '0, interface_wdata = '0, interface_rdata;
  logic        interface_we = 1'b0;
  logic        cpu_rst, cpu_global_en;
  logic        cpu_commit_en = 1'b0, cpu_commit_halt = 1'b0;
  logic [31:0] cpu_commit_pc = '0;

  cpu_run_sequencer #(.RST_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .interface_addr(interface_addr), .interface_wdata(interface_wdata),
    .interface_we(interface_we), .interface_rdata(interface_rdata),
    .cpu_rst(cpu_rst), .cpu_global_en(cpu_global_en),
    .cpu_commit_en(cpu_commit_en), .cpu_commit_pc(cpu_commit_pc),
    .cpu_commit_halt(cpu_commit_halt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_pass = 0;

  // Model: mode uses the architectural codes 0 RST,1 IDLE,2 RUN,3 STEP,4 DONE.
  int          m_mode, m_rst_left;
  logic [31:0] m_nstep, m_cyc, m_inst, m_lpc, m_bp, m_remain;
  logic        m_hbi, m_bph;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_rst_left = 4; m_nstep = 1;
    m_cyc = 0; m_inst = 0; m_lpc = 0; m_bp = 0; m_remain = 0; m_hbi = 0; m_bph = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] off);
    case (off)
      3'd1: return {27'd0, m_bph, m_hbi, 3'(m_mode)};
      3'd2: return m_nstep;
      3'd3: return m_cyc;
      3'd4: return m_inst;
      3'd5: return m_lpc;
`ifdef CPU_SEQ_BREAKPOINT_EN
      3'd6: return m_bp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic we, input logic [2:0] off, input logic [31:0] wd,
                            input logic ce, input logic [31:0] pc, input logic hl);
    bit en, counted, bpm, rst_c, halt_c, step_c, run_c;
    en      = (m_mode == 2) || (m_mode == 3);
    counted = en && ce;
    rst_c   = we && off == 0 && wd[3];
    halt_c  = we && off == 0 && !wd[3] && wd[2];
    step_c  = we && off == 0 && wd[3:2] == 0 && wd[1];
    run_c   = we && off == 0 && wd[3:1] == 0 && wd[0];
`ifdef CPU_SEQ_BREAKPOINT_EN
    bpm = counted && m_bp[0] && (pc >> 2) == (m_bp >> 2);
`else
    bpm = 0;
`endif
    if (we && off == 2) m_nstep = wd;
`ifdef CPU_SEQ_BREAKPOINT_EN
    if (we && off == 6) m_bp = wd;
`endif
    if (en) m_cyc = m_cyc + 1;
    if (counted) begin m_inst = m_inst + 1; m_lpc = pc; end
    if (rst_c) begin
      m_mode = 0; m_rst_left = 4; m_cyc = 0; m_inst = 0; m_lpc = 0; m_hbi = 0; m_bph = 0;
    end else if (m_mode == 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (step_c) begin m_mode = 3; m_remain = (m_nstep == 0) ? 1 : m_nstep; m_bph = 0; end
      else if (run_c) begin m_mode = 2; m_bph = 0; end
    end else if (m_mode == 2 || m_mode == 3) begin
      if (counted && hl) begin m_mode = 4; m_hbi = 1; end
      else if (halt_c) m_mode = 1;
      else if (bpm) begin m_mode = 1; m_bph = 1; end
      else if (m_mode == 3 && counted) begin
        if (m_remain == 1) m_mode = 1;
        else m_remain = m_remain - 1;
      end
    end
  endtask

  // One clock: drive at negedge, compare outputs before the edge, advance the model.
  task automatic tick(input logic we, input logic [2:0] off, input logic [31:0] wd,
                      input logic ce, input logic [31:0] pc, input logic hl,
                      output logic [31:0] rv, output logic en_o, output logic rst_o);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    interface_we = we; interface_addr = {27'd0, off, 2'b00}; interface_wdata = wd;
    cpu_commit_en = ce; cpu_commit_pc = pc; cpu_commit_halt = hl;
    #1;
    chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_mode == 0});
    chk("cpu_global_en", {31'd0, cpu_global_en}, {31'd0, m_mode == 2 || m_mode == 3});
    chk($sformatf("rdata[%0d]", off), interface_rdata, model_rd(off));
    rv = interface_rdata; en_o = cpu_global_en; rst_o = cpu_rst;
    model_step(we, off, wd, ce, pc, hl);
  endtask

  task automatic do_sysrst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      sys_rst = 1'b1; interface_we = 1'b0; cpu_commit_en = 1'b0; cpu_commit_halt = 1'b0;
      @(posedge sys_clk); #1;
      chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rst_gl_en", {31'd0, cpu_global_en}, 32'd0);
    end
    model_reset();
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] rv; logic e, r;
    tick(1'b1, off, wd, 1'b0, 32'd0, 1'b0, rv, e, r);
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
    logic [31:0] rv; logic e, r;
    tick(1'b0, off, 32'd0, 1'b0, 32'd0, 1'b0, rv, e, r);
    chk(name, rv, exp);
  endtask

  task automatic idle(input int n);
    logic [31:0] rv; logic e, r;
    for (int i = 0; i < n; i++) tick(1'b0, 3'd7, 32'd0, 1'b0, 32'd0, 1'b0, rv, e, r);
  endtask

  initial begin
    logic [31:0] rv; logic e, r;
    int rst_cnt, en_cnt;

    // Reset: cpu_rst high exactly RST_CYCLES after release, never enabled.
    do_sysrst(3);
    rst_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 3'd1, 32'd0, 1'b0, 32'd0, 1'b0, rv, e, r);
      rst_cnt += int'(r); en_cnt += int'(e);
    end
    chk("reset_rst_cycles", rst_cnt, 32'd4);
    chk("reset_en_never", en_cnt, 32'd0);
    rd(3'd1, 32'd1, "reset_stat");
    rd(3'd3, 32'd0, "reset_cyc");
    rd(3'd4, 32'd0, "reset_inst");
    rd(3'd2, 32'd1, "reset_nstep");

    // Step 3, commits every cycle.
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h2);
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 3'd7, 32'd0, 1'b1, 32'h100 + 32'(4 * i), 1'b0, rv, e, r);
      en_cnt += int'(e);
    end
    chk("step3_en_cycles", en_cnt, 32'd3);
    rd(3'd4, 32'd3, "step3_inst");
    rd(3'd5, 32'h108, "step3_lpc");
    rd(3'd1, 32'd1, "step3_stat");
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h2);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 3'd7, 32'd0, 1'b1, 32'h200, 1'b0, rv, e, r);
      en_cnt += int'(e);
    end
    chk("step0_en_cycles", en_cnt, 32'd1);
    rd(3'd4, 32'd4, "step0_inst");

    // Run to halt instruction.
    wr(3'd0, 32'h8);
    idle(5);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 14; i++)
      tick(1'b0, 3'd7, 32'd0, i <= 10, 32'h300 + 32'(4 * i), i == 10, rv, e, r);
    rd(3'd1, 32'h0C, "halt_stat");
    rd(3'd4, 32'd11, "halt_inst");
    rd(3'd3, 32'd11, "halt_cyc");
    wr(3'd0, 32'h1);
    idle(3);
    rd(3'd3, 32'd11, "done_run_ignored");

    // Halt mid-run in a commit cycle, then RESET+RUN.
    wr(3'd0, 32'h8);
    idle(5);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 5; i++) tick(1'b0, 3'd7, 32'd0, 1'b1, 32'h400, 1'b0, rv, e, r);
    tick(1'b1, 3'd0, 32'h4, 1'b1, 32'h444, 1'b0, rv, e, r);
    rd(3'd4, 32'd6, "midhalt_inst");
    rd(3'd5, 32'h444, "midhalt_lpc");
    rd(3'd1, 32'd1, "midhalt_stat");
    wr(3'd0, 32'h9);
    rd(3'd1, 32'd0, "rstrun_stat");
    rd(3'd3, 32'd0, "rstrun_cyc");
    rd(3'd4, 32'd0, "rstrun_inst");
    idle(4);
    rd(3'd1, 32'd1, "rstrun_idle");

    // Breakpoint (or its absence).
`ifdef CPU_SEQ_BREAKPOINT_EN
    wr(3'd6, 32'h1D);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 12; i++) tick(1'b0, 3'd7, 32'd0, 1'b1, 32'(4 * i), 1'b0, rv, e, r);
    rd(3'd4, 32'd8, "bp_inst");
    rd(3'd5, 32'h1C, "bp_lpc");
    rd(3'd1, 32'h11, "bp_stat");
    wr(3'd6, 32'h0);
`else
    wr(3'd6, 32'h1D);
    rd(3'd6, 32'd0, "bp_absent");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic we, ce, hl; logic [2:0] off; logic [31:0] wd, pc;
      if ($urandom_range(0, 199) == 0) begin
        do_sysrst($urandom_range(1, 3));
        continue;
      end
      we  = ($urandom_range(0, 3) == 0);
      off = 3'($urandom_range(0, 7));
      wd  = $urandom;
      if (off == 3'd0) wd = {28'd0, ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7))};
      if (off == 3'd2) wd = $urandom_range(0, 5);
      if (off == 3'd6) wd = {26'd0, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1))};
      ce = ($urandom_range(0, 1) == 1);
      pc = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      hl = ($urandom_range(0, 29) == 0);
      tick(we, off, wd, ce, pc, hl, rv, e, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
